// File: rtl/decode_stage.sv
// Instruction decode stage: bypassed 32x32 register file, control decode,
// load-use stall detection and a registered ID/EX boundary.
module decode_stage #(
  parameter int width_B = 32,
  parameter int Addr_B  = 10,
  parameter int Reg_B   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [width_B-1:0] instruccion,
  input  logic [Addr_B-1:0]  pc_plus1,
  input  logic               flush,
  input  logic               ex_mem_read,
  input  logic [Reg_B-1:0]   ex_rt,
  input  logic               wb_we,
  input  logic [Reg_B-1:0]   wb_addr,
  input  logic [width_B-1:0] wb_data,
  output logic               stall,
  output logic               id_valid,
  output logic [Addr_B-1:0]  id_pc_plus1,
  output logic [width_B-1:0] id_rs_data,
  output logic [width_B-1:0] id_rt_data,
  output logic [width_B-1:0] id_imm,
  output logic [Reg_B-1:0]   id_rs,
  output logic [Reg_B-1:0]   id_rt,
  output logic [Reg_B-1:0]   id_rd,
  output logic               id_reg_write,
  output logic               id_mem_read,
  output logic               id_mem_write,
  output logic               id_alu_src,
  output logic               id_reg_dst,
  output logic               id_branch,
  output logic [2:0]         id_alu_op,
  output logic               id_illegal
);

  localparam int NREG = 1 << Reg_B;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // Field extraction
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [Reg_B-1:0] rs;
  logic [Reg_B-1:0] rt;
  logic [Reg_B-1:0] rd;

  assign opcode = instruccion[31:26];
  assign funct  = instruccion[5:0];
  assign rs     = instruccion[25:21];
  assign rt     = instruccion[20:16];
  assign rd     = instruccion[15:11];

  // Register file: r0 has no storage and always reads zero
  logic [width_B-1:0] rf_q [1:NREG-1];

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_rf
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rf_q[gi] <= '0;
        end else if (wb_we && (wb_addr == Reg_B'(gi))) begin
          rf_q[gi] <= wb_data;
        end
      end
    end
  endgenerate

  logic [width_B-1:0] rs_data;
  logic [width_B-1:0] rt_data;

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs != '0) begin
      rs_data = (wb_we && (wb_addr == rs)) ? wb_data : rf_q[rs];
    end
    if (rt != '0) begin
      rt_data = (wb_we && (wb_addr == rt)) ? wb_data : rf_q[rt];
    end
  end

  // Control decode
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_alu_src;
  logic       dec_reg_dst;
  logic       dec_branch;
  logic [2:0] dec_alu_op;
  logic       dec_illegal;
  logic       uses_rt;

  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_src   = 1'b0;
    dec_reg_dst   = 1'b0;
    dec_branch    = 1'b0;
    dec_alu_op    = ALU_ADD;
    dec_illegal   = 1'b0;
    uses_rt       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        // The all-zero word is a NOP and carries no controls or operands
        if (instruccion != '0) begin
          uses_rt       = 1'b1;
          dec_reg_write = 1'b1;
          dec_reg_dst   = 1'b1;
          case (funct)
            FN_ADD:  dec_alu_op = ALU_ADD;
            FN_SUB:  dec_alu_op = ALU_SUB;
            FN_AND:  dec_alu_op = ALU_AND;
            FN_OR:   dec_alu_op = ALU_OR;
            FN_SLT:  dec_alu_op = ALU_SLT;
            default: begin
              dec_illegal   = 1'b1;
              dec_reg_write = 1'b0;
              dec_reg_dst   = 1'b0;
            end
          endcase
        end
      end
      OP_ADDI: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OP_LW: begin
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OP_SW: begin
        uses_rt       = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OP_BEQ: begin
        uses_rt    = 1'b1;
        dec_branch = 1'b1;
        dec_alu_op = ALU_SUB;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Load-use hazard; flush suppresses it so fetch can redirect
  assign stall = !rst && in_valid && !flush && ex_mem_read && (ex_rt != '0) &&
                 ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));

  logic load_entry;
  assign load_entry = in_valid && !flush && !stall;

  // ID/EX boundary
  logic               valid_q;
  logic [Addr_B-1:0]  pc_q;
  logic [width_B-1:0] rs_data_q;
  logic [width_B-1:0] rt_data_q;
  logic [width_B-1:0] imm_q;
  logic [Reg_B-1:0]   rs_q;
  logic [Reg_B-1:0]   rt_q;
  logic [Reg_B-1:0]   rd_q;
  logic               reg_write_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic               alu_src_q;
  logic               reg_dst_q;
  logic               branch_q;
  logic [2:0]         alu_op_q;
  logic               illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      reg_dst_q   <= 1'b0;
      branch_q    <= 1'b0;
      alu_op_q    <= 3'd0;
      illegal_q   <= 1'b0;
    end else if (load_entry) begin
      valid_q     <= 1'b1;
      pc_q        <= pc_plus1;
      rs_data_q   <= rs_data;
      rt_data_q   <= rt_data;
      imm_q       <= {{(width_B-16){instruccion[15]}}, instruccion[15:0]};
      rs_q        <= rs;
      rt_q        <= rt;
      rd_q        <= rd;
      reg_write_q <= dec_reg_write;
      mem_read_q  <= dec_mem_read;
      mem_write_q <= dec_mem_write;
      alu_src_q   <= dec_alu_src;
      reg_dst_q   <= dec_reg_dst;
      branch_q    <= dec_branch;
      alu_op_q    <= dec_alu_op;
      illegal_q   <= dec_illegal;
    end else begin
      // Bubble: data fields keep stale values, controls are cleared
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      reg_dst_q   <= 1'b0;
      branch_q    <= 1'b0;
      alu_op_q    <= 3'd0;
      illegal_q   <= 1'b0;
    end
  end

  assign id_valid     = valid_q;
  assign id_pc_plus1  = pc_q;
  assign id_rs_data   = rs_data_q;
  assign id_rt_data   = rt_data_q;
  assign id_imm       = imm_q;
  assign id_rs        = rs_q;
  assign id_rt        = rt_q;
  assign id_rd        = rd_q;
  assign id_reg_write = reg_write_q;
  assign id_mem_read  = mem_read_q;
  assign id_mem_write = mem_write_q;
  assign id_alu_src   = alu_src_q;
  assign id_reg_dst   = reg_dst_q;
  assign id_branch    = branch_q;
  assign id_alu_op    = alu_op_q;
  assign id_illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: directed scenarios plus random traffic
// checked against a behavioural decode/register-file model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruccion;
  logic [9:0]  pc_plus1;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic        id_valid;
  logic [9:0]  id_pc_plus1;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_alu_src;
  logic        id_reg_dst;
  logic        id_branch;
  logic [2:0]  id_alu_op;
  logic        id_illegal;

  decode_stage #(.width_B(32), .Addr_B(10), .Reg_B(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instruccion(instruccion),
    .pc_plus1(pc_plus1), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .id_valid(id_valid), .id_pc_plus1(id_pc_plus1), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_branch(id_branch), .id_alu_op(id_alu_op), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state and decode
  logic [31:0] model_rf [32];
  bit          model_stall;

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_we && wb_addr == idx) return wb_data;
    return model_rf[idx];
  endfunction

  // ctl = {reg_write, mem_read, mem_write, alu_src, reg_dst, branch, alu_op[2:0], illegal}
  function automatic logic [9:0] model_ctl(input logic [31:0] w, output bit rt_used);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    rt_used = 0;
    if (w == 32'd0) return 10'd0;
    case (op)
      6'h00: begin
        rt_used = 1;
        case (fn)
          6'h20: return 10'b1000_1_0_000_0;
          6'h22: return 10'b1000_1_0_001_0;
          6'h24: return 10'b1000_1_0_010_0;
          6'h25: return 10'b1000_1_0_011_0;
          6'h2A: return 10'b1000_1_0_100_0;
          default: return 10'b0000_0_0_000_1;
        endcase
      end
      6'h08: return 10'b1001_0_0_000_0;
      6'h23: return 10'b1101_0_0_000_0;
      6'h2B: begin rt_used = 1; return 10'b0011_0_0_000_0; end
      6'h04: begin rt_used = 1; return 10'b0000_0_1_001_0; end
      default: return 10'b0000_0_0_000_1;
    endcase
  endfunction

  function automatic logic [9:0] dut_ctl();
    return {id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst,
            id_branch, id_alu_op, id_illegal};
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [9:0] pc,
                       input logic fl, input logic mr, input logic [4:0] er,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    in_valid = v; instruccion = w; pc_plus1 = pc; flush = fl;
    ex_mem_read = mr; ex_rt = er; wb_we = we; wb_addr = wa; wb_data = wd;
  endtask

  // One clock: inputs are already driven (just after negedge)
  task automatic step();
    bit          rt_used;
    logic [9:0]  ctl;
    bit          ld;
    logic [31:0] e_rs, e_rt, e_imm;
    #1;
    ctl = model_ctl(instruccion, rt_used);
    model_stall = in_valid && !flush && ex_mem_read && ex_rt != 0 &&
                  (ex_rt == instruccion[25:21] || (rt_used && ex_rt == instruccion[20:16]));
    check("stall", {31'd0, stall}, {31'd0, model_stall});
    ld    = in_valid && !flush && !model_stall;
    e_rs  = model_read(instruccion[25:21]);
    e_rt  = model_read(instruccion[20:16]);
    e_imm = 32'(signed'(instruccion[15:0]));
    @(posedge clk);
    if (wb_we && wb_addr != 0) model_rf[wb_addr] = wb_data;
    #1;
    check("id_valid", {31'd0, id_valid}, {31'd0, ld});
    check("ctl", {22'd0, dut_ctl()}, ld ? {22'd0, ctl} : 32'd0);
    if (ld) begin
      check("pc", {22'd0, id_pc_plus1}, {22'd0, pc_plus1});
      check("rs_data", id_rs_data, e_rs);
      check("rt_data", id_rt_data, e_rt);
      check("imm", id_imm, e_imm);
      check("regs", {17'd0, id_rs, id_rt, id_rd}, {17'd0, instruccion[25:11]});
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, "_ctl"}, {22'd0, dut_ctl()}, 32'd0);
    check({tag, "_pc"}, {22'd0, id_pc_plus1}, 32'd0);
    check({tag, "_data"}, id_rs_data | id_rt_data | id_imm, 32'd0);
    check({tag, "_regs"}, {17'd0, id_rs, id_rt, id_rd}, 32'd0);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, c;
    logic [15:0] imm;
    logic [5:0]  fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return {6'h00, a, b, c, 5'd0, fns[$urandom_range(0, 4)]};
      4: return {6'h08, a, b, imm};
      5: return {6'h23, a, b, imm};
      6: return {6'h2B, a, b, imm};
      7: return {6'h04, a, b, imm};
      8: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    rst = 1'b1;
    drive(1, 32'h00622020, 10'd1, 0, 1, 5'd3, 0, 5'd0, 32'd0);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Write-back bypass into the same-cycle decode
    drive(1, 32'h00622020, 10'd2, 0, 0, 5'd0, 1, 5'd3, 32'hDEADBEEF);
    step();
    check("bypass_rs", id_rs_data, 32'hDEADBEEF);
    check("bypass_ctl", {22'd0, dut_ctl()}, {22'd0, 10'b1000_1_0_000_0});

    // Sign-extended immediate
    drive(1, 32'h2085FFFC, 10'd3, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    step();
    check("imm_neg", id_imm, 32'hFFFFFFFC);
    check("imm_alu_src", {31'd0, id_alu_src}, 32'd1);
    check("imm_rt", {27'd0, id_rt}, 32'd5);

    // Load-use stall, release, and ex_rt=0 no-stall
    drive(1, 32'h00622020, 10'd4, 0, 1, 5'd2, 0, 5'd0, 32'd0);
    #1 check("lu_stall", {31'd0, stall}, 32'd1);
    step();
    check("lu_bubble", {31'd0, id_valid}, 32'd0);
    drive(1, 32'h00622020, 10'd4, 0, 0, 5'd2, 0, 5'd0, 32'd0);
    step();
    check("lu_release", {31'd0, id_valid}, 32'd1);
    drive(1, 32'h00622020, 10'd5, 0, 1, 5'd0, 0, 5'd0, 32'd0);
    #1 check("lu_r0_nostall", {31'd0, stall}, 32'd0);
    step();

    // Flush wins over stall
    drive(1, 32'h00622020, 10'd6, 1, 1, 5'd2, 0, 5'd0, 32'd0);
    #1 check("flush_stall", {31'd0, stall}, 32'd0);
    step();
    check("flush_bubble", {31'd0, id_valid}, 32'd0);

    // r0 ignores writes and is not bypassed
    drive(1, 32'h00002020, 10'd7, 0, 0, 5'd0, 1, 5'd0, 32'h00001234);
    step();
    check("r0_bypass", id_rs_data, 32'd0);
    drive(1, 32'h00002020, 10'd8, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    step();
    check("r0_read", id_rs_data, 32'd0);

    // Illegal opcode
    drive(1, 32'hFC000000, 10'd9, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    step();
    check("illegal_flag", {31'd0, id_illegal}, 32'd1);
    check("illegal_valid", {31'd0, id_valid}, 32'd1);

    // Random traffic; fetch holds its inputs while stalled
    model_stall = 0;
    for (int n = 0; n < 400; n++) begin
      if (model_stall) begin
        ex_mem_read = ($urandom_range(0, 1) == 1);
        ex_rt = 5'($urandom_range(0, 7));
        flush = ($urandom_range(0, 9) == 0);
        wb_we = $urandom_range(0, 1) == 1;
        wb_addr = 5'($urandom_range(0, 7));
        wb_data = $urandom;
      end else begin
        drive($urandom_range(0, 19) != 0, rand_instr(), 10'($urandom),
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3,
              5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 7)), $urandom);
      end
      step();
    end

    // Mid-stream async reset with a live hazard on the inputs
    drive(1, 32'h00622020, 10'd10, 0, 0, 5'd0, 1, 5'd5, 32'h55AA55AA);
    step();
    drive(1, 32'h00A22020, 10'd11, 0, 1, 5'd5, 0, 5'd0, 32'd0);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    drive(1, 32'h00A00820, 10'd12, 0, 0, 5'd0, 0, 5'd0, 32'd0);
    step();
    check("rst_r5", id_rs_data, 32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage, directly downstream of instruction fetch.
- Consumes the 32-bit MIPS-style instruction word and its PC+1.
- Reads a 32x32 register file with write-back bypass, decodes control signals and sign-extends the immediate.
- Detects load-use hazards and raises a stall toward fetch; all results go through a registered ID/EX boundary.

Parameters:
- width_B, 32, data/instruction width
- Addr_B, 10, PC/instruction address width
- Reg_B, 5, register index width (32 registers)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  instruccion/pc_plus1 are valid this cycle
- instruccion  input  width_B  instruction word from fetch
- pc_plus1  input  Addr_B  PC+1 of that instruction
- flush  input  1  kill the instruction currently in decode
- ex_mem_read  input  1  instruction in EX is a load
- ex_rt  input  Reg_B  destination of the load in EX
- wb_we  input  1  register-file write enable
- wb_addr  input  Reg_B  write-back register index
- wb_data  input  width_B  write-back data
- stall  output  1  combinational; fetch must hold PC and instruction
- id_valid  output  1  ID/EX entry holds a real instruction
- id_pc_plus1  output  Addr_B  registered pc_plus1
- id_rs_data, id_rt_data  output  width_B  operand values
- id_imm  output  width_B  sign-extended instruccion[15:0]
- id_rs, id_rt, id_rd  output  Reg_B  register indices
- id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_branch  output  1 each  control signals
- id_alu_op  output  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT
- id_illegal  output  1  unsupported opcode/funct

Behaviour:
- Reset (async): all register-file entries = 0. Every id_* output = 0. stall is 0 while rst=1.
- Register file:
  - r0 reads 0 and ignores writes.
  - A write occurs on clk when wb_we=1 and wb_addr!=0.
  - Reads are combinational with bypass: if wb_we && wb_addr==index && index!=0, the read returns wb_data in the same cycle.
- Decode by opcode (instruccion[31:26]):
  - R-type (0x00), by funct:
    - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
    - reg_write=1, reg_dst=1, alu_src=0.
    - Word 0x00000000 is a NOP: id_valid=1, all controls 0, illegal=0.
  - 0x08 addi: reg_write, alu_src, ADD.
  - 0x23 lw: reg_write, mem_read, alu_src, ADD.
  - 0x2B sw: mem_write, alu_src, ADD.
  - 0x04 beq: branch, SUB.
  - Anything else: illegal=1, all controls 0, id_valid=1.
- "uses_rt" is true for R-type (except NOP), sw and beq.
- Hazard (combinational):
  - stall = in_valid && !flush && ex_mem_read && ex_rt!=0 && (ex_rt==rs || (uses_rt && ex_rt==rt)).
- ID/EX update on each rising edge, in priority order:
  1. flush → bubble.
  2. stall → bubble.
  3. !in_valid → bubble.
  4. Otherwise load the decoded instruction with id_valid=1.
- Bubble definition: id_valid=0 and all control outputs 0. Data fields may hold don't-care values; the bench checks them only when id_valid=1.
- Latency: an instruction presented in cycle n appears on id_* in cycle n+1.
- During stall, fetch holds its inputs stable. The same instruction is re-decoded the next cycle with fresh operands, including bypassed write-back.
- flush and stall in the same cycle: result is a bubble and stall=0, so fetch is free to redirect.
- rst asserted mid-operation clears the ID/EX entry and the register file immediately. The first valid instruction after release decodes normally.
- Widths:
  - Immediate: sign-extended from bit 15.
  - id_rs=[25:21], id_rt=[20:16], id_rd=[15:11], regardless of format.

Test Plan:
- Reset: assert rst mid-stream → all id_* = 0 and stall=0 within the same cycle. Then read r5 → 0.
- Write-back bypass: wb_we=1, wb_addr=3, wb_data=0xDEADBEEF, same cycle as instruccion=0x00622020 (add r4,r3,r2) → next cycle id_rs_data=0xDEADBEEF, id_alu_op=0, id_reg_write=1, id_reg_dst=1.
- Immediate: instruccion=0x2085FFFC (addi r5,r4,-4) → id_imm=0xFFFFFFFC, id_alu_src=1, id_rt=5.
- Load-use: ex_mem_read=1, ex_rt=2, instruccion=0x00622020 → stall=1 and id_valid=0 next cycle. Drop ex_mem_read → id_valid=1 the following cycle. Same test with ex_rt=0 → no stall.
- Flush priority: flush=1 together with a stall condition → stall=0, id_valid=0.
- Writes to r0 and illegal opcode: wb to r0 with 0x1234, then read r0 → 0. instruccion=0xFC000000 → id_illegal=1, all controls 0.
